serial_word_tx: RTL and testbench

- Parallel-in, serial-out word transmitter. It is the source end of the serial bit-stream interface used by the serial 2's-complementer (x_in/y_out style).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first on x_out, one bit per clock.
- Provides frame markers so a downstream serial block can be reset or re-armed between words.
- Sits between a parallel producer (bench or register) and any single-bit serial consumer.

---
 rtl/serial_word_tx_pkg.sv | 24 ++
 rtl/serial_word_tx.sv | 145 ++++++++++++++
 tb/tb_serial_word_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_tx_pkg.sv
// ============================================================================
// Module   : serial_word_tx_pkg
// Brief    : Shared state encodings and default sizing for the serial word link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package serial_word_tx_pkg;

  localparam int c_def_width      = 8;
  localparam int c_def_gap_cycles = 1;

  // Encodings are shared with the matching receiver, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_word_tx.sv
// ============================================================================
// Module   : serial_word_tx
// Brief    : Parallel-in, LSB-first serial-out word transmitter with frame
//            markers. Define SERIAL_WORD_TX_PARITY_EN to append an even
//            parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH      = c_def_width,
  parameter int GAP_CYCLES = c_def_gap_cycles
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int            c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_pen_bit  = c_cnt_w'(WIDTH - 2);
  localparam logic [3:0]    c_gap_last = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            c_has_gap  = (GAP_CYCLES > 0);

  tx_state_t            r_state;
  logic [WIDTH-1:0]     r_shreg;
  logic [c_cnt_w-1:0]   r_bit_cnt;
  logic [3:0]           r_gap_cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign din_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      x_out       <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (din_valid) begin
            // Bit 0 goes straight out; the register keeps the remainder.
            r_state     <= SHIFT;
            r_shreg     <= din >> 1;
            r_bit_cnt   <= '0;
            x_out       <= din[0];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
            busy        <= 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
            r_parity    <= ^din;
`endif
          end
        end

        SHIFT: begin
          frame_start <= 1'b0;
          if (r_bit_cnt == c_last_bit) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
            r_state   <= PAR;
            x_out     <= r_parity;
            frame_end <= 1'b1;
`else
            x_out     <= 1'b0;
            bit_valid <= 1'b0;
            frame_end <= 1'b0;
            r_gap_cnt <= '0;
            if (c_has_gap) begin
              r_state <= GAP;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            x_out     <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
`ifndef SERIAL_WORD_TX_PARITY_EN
            frame_end <= (r_bit_cnt == c_pen_bit);
`endif
          end
        end

`ifdef SERIAL_WORD_TX_PARITY_EN
        PAR: begin
          x_out     <= 1'b0;
          bit_valid <= 1'b0;
          frame_end <= 1'b0;
          r_gap_cnt <= '0;
          if (c_has_gap) begin
            r_state <= GAP;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
`endif

        GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end

        default: begin
          r_state     <= IDLE;
          x_out       <= 1'b0;
          bit_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// ============================================================================
// Module   : tb_serial_word_tx
// Brief    : Scoreboard bench for serial_word_tx (GAP_CYCLES=1 and =0 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic x;
    logic fs;
    logic fe;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, x_a, bv_a, fs_a, fe_a, busy_a;
  logic       ready_b, x_b, bv_b, fs_b, fe_b, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .x_out(x_a), .bit_valid(bv_a), .frame_start(fs_a), .frame_end(fe_a), .busy(busy_a)
  );

  serial_word_tx #(.WIDTH(8), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .x_out(x_b), .bit_valid(bv_b), .frame_start(fs_b), .frame_end(fe_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit sel, input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.x  = w[i];
      e.fs = (i == 0);
      e.fe = (i == 7) && (PB == 0);
      if (sel) q_b.push_back(e); else q_a.push_back(e);
    end
    if (PB != 0) begin
      e.x  = ^w;
      e.fs = 1'b0;
      e.fe = 1'b1;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  task automatic mon(input bit sel, input logic x, input logic bv, input logic fs, input logic fe);
    exp_t  e;
    string nm;
    nm = sel ? "b" : "a";
    if (bv) begin
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s_unexpected_bit: got x=%0b fs=%0b fe=%0b, expected no frame bit", nm, x, fs, fe);
      end else begin
        e = sel ? q_b.pop_front() : q_a.pop_front();
        chk({nm, "_x_out"}, 32'(x), 32'(e.x));
        chk({nm, "_frame_start"}, 32'(fs), 32'(e.fs));
        chk({nm, "_frame_end"}, 32'(fe), 32'(e.fe));
      end
    end else begin
      chk({nm, "_idle_outputs"}, 32'({x, fs, fe}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      mon(1'b0, x_a, bv_a, fs_a, fe_a);
      mon(1'b1, x_b, bv_b, fs_b, fe_b);
    end
  end

  // Called right after a negedge; returns at the negedge following the accept.
  task automatic send(input bit sel, input logic [7:0] w, input bit keep, output time t_acc);
    bit rdy;
    t_acc = 0;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rdy = sel ? ready_b : ready_a;
      if (rdy) break;
      if (sel) din_b = 8'($urandom); else din_a = 8'($urandom);
      @(negedge clk);
    end
    rdy = sel ? ready_b : ready_a;
    if (!rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: din_ready got 0, expected 1");
      if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    end else begin
      if (sel) din_b = w; else din_a = w;
      push_frame(sel, w);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      if (sel) din_b = 8'($urandom); else din_a = 8'($urandom);
      if (!keep) begin
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
      end
    end
  endtask

  task automatic wait_ready(input bit sel, output time t);
    t = 0;
    for (int k = 0; k < 40; k++) begin
      if (sel ? ready_b : ready_a) begin
        t = $time;
        break;
      end
      @(negedge clk);
    end
    if (t == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: din_ready got 0, expected 1");
    end
  endtask

  initial begin
    time t0, t1, t2;
    din_a = 8'h00; din_b = 8'h00; valid_a = 1'b0; valid_b = 1'b0;
    rstn = 1'b0;
    #1;
    chk("reset_ready_a", 32'(ready_a), 32'd1);
    chk("reset_outs_a", 32'({x_a, bv_a, fs_a, fe_a, busy_a}), 32'd0);
    chk("reset_ready_b", 32'(ready_b), 32'd1);
    chk("reset_outs_b", 32'({x_b, bv_b, fs_b, fe_b, busy_b}), 32'd0);
    #1 rstn = 1'b1;

    // Idle with no valid input
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready_a), 32'd1);
      chk("idle_busy", 32'(busy_a), 32'd0);
    end

    // Single frame B4, then one gap cycle before ready
    send(1'b0, 8'hB4, 1'b0, t0);
    wait_ready(1'b0, t1);
    chk("gap_ready_delay", 32'(t1 - t0), 32'(95 + 10 * PB));

    // Back-to-back with valid held high and din scrambled while busy
    send(1'b0, 8'h01, 1'b1, t0);
    send(1'b0, 8'hFF, 1'b0, t1);
    chk("b2b_period", 32'(t1 - t0), 32'(100 + 10 * PB));

    // Abort during bit 4
    send(1'b0, 8'hA5, 1'b0, t0);
    repeat (4) @(negedge clk);
    #1 rstn = 1'b0;
    q_a.delete();
    #1;
    chk("abort_outputs", 32'({x_a, bv_a, fs_a, fe_a, busy_a}), 32'd0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 32'(busy_a), 32'd0);
    send(1'b0, 8'h3C, 1'b0, t0);

    // No-gap instance, back-to-back 55 then AA
    send(1'b1, 8'h55, 1'b1, t0);
    send(1'b1, 8'hAA, 1'b0, t1);
    chk("nogap_period", 32'(t1 - t0), 32'(90 + 10 * PB));
    wait_ready(1'b1, t2);
    chk("nogap_ready_delay", 32'(t2 - t1), 32'(85 + 10 * PB));

    // Odd-parity word
    wait_ready(1'b0, t1);
    send(1'b0, 8'h07, 1'b0, t0);

    for (int k = 0; k < 40; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_pending", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
